bne_instruction: RTL and testbench

//   Branch-if-not-equal next-PC resolver for the 19-bit control-flow unit.

---
 rtl/bne_instruction.sv | 68 ++++++
 tb/tb_bne_instruction.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/bne_instruction.sv
// Branch-if-not-equal next-PC resolver: registers branch_addr when r2 != r3, else pc_next.
// Latency: 1 cycle from an in_valid edge to pc/taken/out_valid.
// Backpressure: none; a resolve is accepted on every edge with in_valid=1.
//
// Optional feature macro: BNE_TAKEN_CNT_EN (adds the saturating taken_cnt output).
//
// Ports:
//   clk          rising-edge clock
//   rst          synchronous active-high reset, wins over in_valid
//   in_valid     operands/addresses valid; resolve on this edge
//   r2, r3       compare operands (full-width unsigned compare)
//   branch_addr  target PC when r2 != r3
//   pc_next      fall-through PC when r2 == r3
//   pc           resolved program counter (registered)
//   out_valid    pc was updated by a resolve on the previous edge
//   taken        the last resolve took the branch
//   taken_cnt    saturating taken-branch count (BNE_TAKEN_CNT_EN only)
module bne_instruction #(
   parameter int               WIDTH    = 19,
   parameter logic [WIDTH-1:0] RESET_PC = '0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   input  logic [WIDTH-1:0] r2,
   input  logic [WIDTH-1:0] r3,
   input  logic [WIDTH-1:0] branch_addr,
   input  logic [WIDTH-1:0] pc_next,
   output logic [WIDTH-1:0] pc,
   output logic             out_valid,
   output logic             taken
`ifdef BNE_TAKEN_CNT_EN
   ,
   output logic [15:0]      taken_cnt
`endif
);

   // Full-width bitwise compare; no sign interpretation of the operands.
   logic not_equal;
   assign not_equal = (r2 != r3);

   // pc and taken hold across idle cycles; only out_valid drops.
   always_ff @(posedge clk) begin
      if (rst) begin
         pc        <= RESET_PC;
         out_valid <= 1'b0;
         taken     <= 1'b0;
      end else if (in_valid) begin
         pc        <= not_equal ? branch_addr : pc_next;
         out_valid <= 1'b1;
         taken     <= not_equal;
      end else begin
         out_valid <= 1'b0;
      end
   end

`ifdef BNE_TAKEN_CNT_EN
   // Sticks at all-ones rather than wrapping so a long run never reads as few branches.
   always_ff @(posedge clk) begin
      if (rst) begin
         taken_cnt <= 16'd0;
      end else if (in_valid && not_equal && (taken_cnt != 16'hFFFF)) begin
         taken_cnt <= taken_cnt + 16'd1;
      end
   end
`endif

endmodule

// File: tb/tb_bne_instruction.sv
module tb_bne_instruction;

   localparam int W = 19;

   logic         clk = 1'b0;
   logic         rst;
   logic         in_valid;
   logic [W-1:0] r2, r3, branch_addr, pc_next;
   logic [W-1:0] pc;
   logic         out_valid, taken;
`ifdef BNE_TAKEN_CNT_EN
   logic [15:0]  taken_cnt;
`endif

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   bne_instruction #(.WIDTH(W), .RESET_PC('0)) dut (
      .clk         (clk),
      .rst         (rst),
      .in_valid    (in_valid),
      .r2          (r2),
      .r3          (r3),
      .branch_addr (branch_addr),
      .pc_next     (pc_next),
      .pc          (pc),
      .out_valid   (out_valid),
      .taken       (taken)
`ifdef BNE_TAKEN_CNT_EN
      ,
      .taken_cnt   (taken_cnt)
`endif
   );

   typedef struct {
      logic         rst;
      logic         iv;
      logic [W-1:0] r2;
      logic [W-1:0] r3;
      logic [W-1:0] ba;
      logic [W-1:0] pn;
      logic [W-1:0] exp_pc;
      logic         exp_ov;
      logic         exp_taken;
      int           exp_cnt;
   } vec_t;

   vec_t vecs[12];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic drive(input logic r, input logic v, input logic [W-1:0] a,
                        input logic [W-1:0] b, input logic [W-1:0] ba, input logic [W-1:0] pn);
      rst = r; in_valid = v; r2 = a; r3 = b; branch_addr = ba; pc_next = pn;
   endtask

   // Advance one edge and land 1 time unit after it, away from the active edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Reference model state (spec-level: what the fetch stage should see).
   logic [W-1:0] m_pc;
   logic         m_ov, m_taken;
   int           m_cnt;

   task automatic model_step(input logic r, input logic v, input logic [W-1:0] a,
                             input logic [W-1:0] b, input logic [W-1:0] ba, input logic [W-1:0] pn);
      if (r) begin
         m_pc = '0; m_ov = 1'b0; m_taken = 1'b0; m_cnt = 0;
      end else if (!v) begin
         m_ov = 1'b0;
      end else begin
         m_ov    = 1'b1;
         m_taken = (a != b);
         m_pc    = m_taken ? ba : pn;
         if (m_taken && m_cnt < 65535) m_cnt = m_cnt + 1;
      end
   endtask

   initial begin
      //          rst   iv    r2         r3         ba         pn         exp_pc     ov    tk    cnt
      vecs[0]  = '{1'b1, 1'b0, 19'd0,     19'd0,     19'd0,     19'd0,     19'd0,     1'b0, 1'b0, 0};
      vecs[1]  = '{1'b1, 1'b0, 19'd0,     19'd0,     19'd0,     19'd0,     19'd0,     1'b0, 1'b0, 0};
      vecs[2]  = '{1'b0, 1'b1, 19'd3,     19'd2,     19'd500,   19'd150,   19'd500,   1'b1, 1'b1, 1};
      vecs[3]  = '{1'b0, 1'b0, 19'd9,     19'd1,     19'd77,    19'd88,    19'd500,   1'b0, 1'b1, 1};
      vecs[4]  = '{1'b0, 1'b1, 19'd7,     19'd7,     19'd500,   19'd150,   19'd150,   1'b1, 1'b0, 1};
      vecs[5]  = '{1'b0, 1'b1, 19'h7FFFF, 19'h3FFFF, 19'h7FFFF, 19'd0,     19'h7FFFF, 1'b1, 1'b1, 2};
      vecs[6]  = '{1'b0, 1'b1, 19'd0,     19'd0,     19'd123,   19'd123,   19'd123,   1'b1, 1'b0, 2};
      vecs[7]  = '{1'b0, 1'b1, 19'd1,     19'd0,     19'd123,   19'd123,   19'd123,   1'b1, 1'b1, 3};
      vecs[8]  = '{1'b1, 1'b1, 19'd5,     19'd6,     19'd777,   19'd1,     19'd0,     1'b0, 1'b0, 0};
      vecs[9]  = '{1'b0, 1'b1, 19'h40000, 19'd0,     19'h12345, 19'd1,     19'h12345, 1'b1, 1'b1, 1};
      vecs[10] = '{1'b0, 1'b0, 19'd4,     19'd4,     19'd0,     19'd0,     19'h12345, 1'b0, 1'b1, 1};
      vecs[11] = '{1'b0, 1'b1, 19'h2AAAA, 19'h2AAAA, 19'd1,     19'h7FFFE, 19'h7FFFE, 1'b1, 1'b0, 1};

      drive(1'b1, 1'b0, '0, '0, '0, '0);

      // Directed table.
      foreach (vecs[i]) begin
         drive(vecs[i].rst, vecs[i].iv, vecs[i].r2, vecs[i].r3, vecs[i].ba, vecs[i].pn);
         tick();
         chk($sformatf("vec%0d_pc", i),        32'(pc),        32'(vecs[i].exp_pc));
         chk($sformatf("vec%0d_out_valid", i), 32'(out_valid), 32'(vecs[i].exp_ov));
         chk($sformatf("vec%0d_taken", i),     32'(taken),     32'(vecs[i].exp_taken));
`ifdef BNE_TAKEN_CNT_EN
         chk($sformatf("vec%0d_taken_cnt", i), 32'(taken_cnt), 32'(vecs[i].exp_cnt));
`endif
      end

      // Outputs must not move when inputs change between edges.
      drive(1'b0, 1'b1, 19'd1, 19'd2, 19'h55555, 19'd9);
      #2;
      chk("no_comb_path_pc",    32'(pc),        32'(19'h7FFFE));
      chk("no_comb_path_taken", 32'(taken),     32'(1'b0));
      tick();
      chk("after_comb_pc",      32'(pc),        32'(19'h55555));
      chk("after_comb_taken",   32'(taken),     32'(1'b1));

      // Back-to-back resolves, one per edge, then reset on a taken edge.
      drive(1'b0, 1'b1, 19'd8, 19'd8, 19'd10, 19'd20);
      tick();
      chk("b2b_0_pc", 32'(pc), 32'(19'd20));
      drive(1'b0, 1'b1, 19'd8, 19'd9, 19'd30, 19'd40);
      tick();
      chk("b2b_1_pc", 32'(pc), 32'(19'd30));
      chk("b2b_1_ov", 32'(out_valid), 32'(1'b1));
      drive(1'b1, 1'b1, 19'd1, 19'd2, 19'd99, 19'd98);
      tick();
      chk("rst_mid_pc",    32'(pc),        32'(19'd0));
      chk("rst_mid_taken", 32'(taken),     32'(1'b0));
      chk("rst_mid_ov",    32'(out_valid), 32'(1'b0));

      // Randomised run against the reference model; model starts from the reset just applied.
      m_pc = '0; m_ov = 1'b0; m_taken = 1'b0; m_cnt = 0;
      for (int k = 0; k < 400; k++) begin
         logic         rr, vv;
         logic [W-1:0] a, b, ba, pn;
         rr = ($urandom_range(0, 19) == 0);
         vv = ($urandom_range(0, 3) != 0);
         a  = W'($urandom);
         b  = ($urandom_range(0, 2) == 0) ? a : W'($urandom);
         ba = W'($urandom);
         pn = ($urandom_range(0, 9) == 0) ? ba : W'($urandom);
         drive(rr, vv, a, b, ba, pn);
         model_step(rr, vv, a, b, ba, pn);
         tick();
         chk($sformatf("rnd%0d_pc", k),        32'(pc),        32'(m_pc));
         chk($sformatf("rnd%0d_out_valid", k), 32'(out_valid), 32'(m_ov));
         chk($sformatf("rnd%0d_taken", k),     32'(taken),     32'(m_taken));
`ifdef BNE_TAKEN_CNT_EN
         chk($sformatf("rnd%0d_taken_cnt", k), 32'(taken_cnt), 32'(m_cnt));
`endif
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
